// File: rtl/axis_packet_ingress_if.sv
// axis_packet_ingress_if: AXI stream link (tdata/tlast/tvalid/tready) plus upstream terr and FIFO tdrop request / tdropped status
interface axis_packet_ingress_if #(
  parameter int TDATA_WIDTH = 32
);
  logic [TDATA_WIDTH-1:0] tdata;
  logic tlast;
  logic terr;
  logic tdrop;
  logic tdropped;
  logic tvalid;
  logic tready;
  modport master (output tdata, tlast, terr, tdrop, tvalid, input tready, tdropped);
  modport slave (input tdata, tlast, terr, tdrop, tvalid, output tready, tdropped);
endinterface

// File: rtl/axis_packet_ingress.sv
// axis_packet_ingress: polices packets (length, terr) from s_axis (slave) into the FIFO on m_axis (master) through one register stage; stat_clear/stat_* counters exist only with AXIS_INGRESS_STATS_EN
module axis_packet_ingress #(
  parameter int TDATA_WIDTH = 32,
  parameter int MIN_BEATS = 2,
  parameter int MAX_BEATS = 64,
  parameter int CNT_WIDTH = 16
) (
  input  logic clk,
  input  logic reset,
  axis_packet_ingress_if.slave s_axis,
  axis_packet_ingress_if.master m_axis,
  input  logic stat_clear,
  output logic [CNT_WIDTH-1:0] stat_ok,
  output logic [CNT_WIDTH-1:0] stat_fifo_drop,
  output logic [CNT_WIDTH-1:0] stat_len_drop,
  output logic [CNT_WIDTH-1:0] stat_err_drop
);
  localparam int BW = $clog2(MAX_BEATS + 2);
  localparam logic [BW-1:0] SAT = BW'(MAX_BEATS + 1);
  localparam logic [BW-1:0] MAXB = BW'(MAX_BEATS);
  localparam logic [BW-1:0] MINB = BW'(MIN_BEATS);
  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;
  state_t state, state_nxt;
  logic [BW-1:0] cnt, beat;
  logic s_hs, drop;
  assign s_axis.tready = !m_axis.tvalid || m_axis.tready;
  assign s_axis.tdropped = 1'b0;
  assign m_axis.terr = 1'b0;
  assign s_hs = s_axis.tvalid && s_axis.tready;
  assign beat = cnt == SAT ? cnt : cnt + BW'(1);
  assign drop = state == DROP || s_axis.terr || beat > MAXB || (s_axis.tlast && beat < MINB);
  always_comb begin
    state_nxt = state;
    if (s_hs)
      state_nxt = s_axis.tlast ? IDLE : (state == DROP || s_axis.terr || beat == SAT) ? DROP : PASS;
  end
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      m_axis.tvalid <= 1'b0;
      m_axis.tdata <= '0;
      m_axis.tlast <= 1'b0;
      m_axis.tdrop <= 1'b0;
    end else if (s_hs) begin
      cnt <= s_axis.tlast ? '0 : beat;
      m_axis.tvalid <= 1'b1;
      m_axis.tdata <= s_axis.tdata;
      m_axis.tlast <= s_axis.tlast;
      m_axis.tdrop <= drop;
    end else if (m_axis.tready) begin
      m_axis.tvalid <= 1'b0;
    end
  end
`ifdef AXIS_INGRESS_STATS_EN
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  logic cause, m_cause, last_hs;
  assign last_hs = m_axis.tvalid && m_axis.tready && m_axis.tlast;
  always_ff @(posedge clk) begin
    if (reset) begin
      cause <= 1'b0;
      m_cause <= 1'b0;
    end else if (s_hs) begin
      cause <= state == DROP ? cause : s_axis.terr;
      m_cause <= state == DROP ? cause : s_axis.terr;
    end
  end
  always_ff @(posedge clk) begin
    if (reset || stat_clear) begin
      stat_ok <= '0;
      stat_fifo_drop <= '0;
      stat_len_drop <= '0;
      stat_err_drop <= '0;
    end else if (last_hs) begin
      if (m_axis.tdrop && m_cause && !(&stat_err_drop))
        stat_err_drop <= stat_err_drop + ONE;
      if (m_axis.tdrop && !m_cause && !(&stat_len_drop))
        stat_len_drop <= stat_len_drop + ONE;
      if (!m_axis.tdrop && m_axis.tdropped && !(&stat_fifo_drop))
        stat_fifo_drop <= stat_fifo_drop + ONE;
      if (!m_axis.tdrop && !m_axis.tdropped && !(&stat_ok))
        stat_ok <= stat_ok + ONE;
    end
  end
`else
  logic unused;
  assign unused = ^{stat_clear, m_axis.tdropped};
  assign stat_ok = '0;
  assign stat_fifo_drop = '0;
  assign stat_len_drop = '0;
  assign stat_err_drop = '0;
`endif
endmodule

// File: tb/tb_axis_packet_ingress.sv
// tb_axis_packet_ingress: packet table plus scoreboard checks of forwarding, drop marking, stalls and counters
module tb_axis_packet_ingress;
  localparam int W = 32;
  localparam int MINB = 2;
  localparam int MAXB = 64;
`ifdef AXIS_INGRESS_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stat_clear = 1'b0;
  logic stat_clear2 = 1'b0;
  logic bp = 1'b0;
  logic [15:0] st_ok, st_fifo, st_len, st_err;
  logic [1:0] s2_ok, s2_fifo, s2_len, s2_err;
  always #5 clk = ~clk;
  axis_packet_ingress_if #(.TDATA_WIDTH(W)) s ();
  axis_packet_ingress_if #(.TDATA_WIDTH(W)) m ();
  axis_packet_ingress_if #(.TDATA_WIDTH(8)) s2 ();
  axis_packet_ingress_if #(.TDATA_WIDTH(8)) m2 ();
  axis_packet_ingress #(.TDATA_WIDTH(W), .MIN_BEATS(MINB), .MAX_BEATS(MAXB), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .s_axis(s), .m_axis(m), .stat_clear(stat_clear),
    .stat_ok(st_ok), .stat_fifo_drop(st_fifo), .stat_len_drop(st_len), .stat_err_drop(st_err));
  axis_packet_ingress #(.TDATA_WIDTH(8), .MIN_BEATS(2), .MAX_BEATS(8), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .s_axis(s2), .m_axis(m2), .stat_clear(stat_clear2),
    .stat_ok(s2_ok), .stat_fifo_drop(s2_fifo), .stat_len_drop(s2_len), .stat_err_drop(s2_err));
  typedef struct packed {
    logic [W-1:0] data;
    logic last;
    logic drop;
    logic cause;
    logic dropped;
  } beat_t;
  typedef struct {
    int len;
    int eb;
    bit dropped;
    int ok;
    int fifo;
    int len_d;
    int err_d;
  } vec_t;
  beat_t q[$];
  beat_t mb;
  int errors = 0;
  int checks = 0;
  int e_ok = 0, e_fifo = 0, e_len = 0, e_err = 0;
  logic stall_v = 1'b0;
  logic [W+1:0] stall_snap;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    m.tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  always @(negedge clk) begin
    if (!reset) begin
      if (stall_v)
        check("stall_hold", {m.tvalid, m.tdata, m.tlast, m.tdrop}, {1'b1, stall_snap});
      stall_v = m.tvalid && !m.tready;
      stall_snap = {m.tdata, m.tlast, m.tdrop};
      if (stall_v)
        check("stall_s_tready", s.tready, 0);
      if (q.size() != 0)
        m.tdropped = q[0].dropped;
      if (m.tvalid && m.tready) begin
        check("beat_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          mb = q.pop_front();
          check("beat_data", m.tdata, mb.data);
          check("beat_last", m.tlast, mb.last);
          check("beat_drop", m.tdrop, mb.drop);
          if (mb.last) begin
            if (mb.drop) begin
              if (mb.cause)
                e_err++;
              else
                e_len++;
            end else if (mb.dropped)
              e_fifo++;
            else
              e_ok++;
          end
        end
      end
    end
  end
  task automatic send_beat(input logic [W-1:0] d, input bit last, input bit err, input bit drop, input bit cause, input bit dropped);
    int n = 0;
    s.tdata = d;
    s.tlast = last;
    s.terr = err;
    s.tvalid = 1'b1;
    @(negedge clk);
    while (!s.tready) begin
      n++;
      if (n > 1000) begin
        $display("FAIL send_timeout: s_axis_tready stuck at %0d, expected 1", s.tready);
        $fatal(1);
      end
      @(negedge clk);
    end
    q.push_back('{data: d, last: last, drop: drop, cause: cause, dropped: dropped});
    @(posedge clk);
    #1;
    s.tvalid = 1'b0;
    s.tlast = 1'b0;
    s.terr = 1'b0;
  endtask
  task automatic send_pkt(input int len, input int eb, input bit dropped);
    int lb;
    bit cause;
    lb = len > MAXB ? MAXB + 1 : len < MINB ? len : len + 1;
    cause = eb != 0 && eb <= lb;
    for (int i = 1; i <= len; i++)
      send_beat($urandom, i == len, i == eb, (eb != 0 && i >= eb) || i >= lb, cause, dropped);
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("drain", q.size(), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask
  task automatic check_stats(input int ok, input int fifo, input int len_d, input int err_d);
    check("stat_ok", st_ok, STATS ? ok : 0);
    check("stat_fifo_drop", st_fifo, STATS ? fifo : 0);
    check("stat_len_drop", st_len, STATS ? len_d : 0);
    check("stat_err_drop", st_err, STATS ? err_d : 0);
  endtask
  initial begin
    vec_t v[10];
    int base;
    v[0] = '{4, 0, 1'b0, 1, 0, 0, 0};
    v[1] = '{66, 0, 1'b0, 1, 0, 1, 0};
    v[2] = '{2, 0, 1'b0, 2, 0, 1, 0};
    v[3] = '{1, 0, 1'b0, 2, 0, 2, 0};
    v[4] = '{5, 3, 1'b0, 2, 0, 2, 1};
    v[5] = '{3, 0, 1'b1, 2, 1, 2, 1};
    v[6] = '{1, 1, 1'b0, 2, 1, 2, 2};
    v[7] = '{65, 65, 1'b0, 2, 1, 2, 3};
    v[8] = '{64, 0, 1'b0, 3, 1, 2, 3};
    v[9] = '{66, 66, 1'b0, 3, 1, 3, 3};
    s.tvalid = 1'b0;
    s.tlast = 1'b0;
    s.terr = 1'b0;
    s.tdrop = 1'b0;
    s.tdata = '0;
    s2.tvalid = 1'b0;
    s2.tlast = 1'b0;
    s2.terr = 1'b0;
    s2.tdrop = 1'b0;
    s2.tdata = '0;
    m.tready = 1'b1;
    m.tdropped = 1'b0;
    m2.tready = 1'b1;
    m2.tdropped = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_m_tvalid", m.tvalid, 0);
    check("rst_m_tdrop", m.tdrop, 0);
    check("rst_m_tlast", m.tlast, 0);
    check("rst_m_tdata", m.tdata, 0);
    check("rst_s_tready", s.tready, 1);
    check_stats(0, 0, 0, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      send_pkt(v[i].len, v[i].eb, v[i].dropped);
      drain();
      check_stats(v[i].ok, v[i].fifo, v[i].len_d, v[i].err_d);
      @(posedge clk);
      #1;
    end
    base = e_ok + e_fifo + e_len + e_err;
    bp = 1'b1;
    for (int p = 0; p < 20; p++) begin
      int len;
      int eb;
      len = $urandom_range(1, 6);
      eb = $urandom_range(0, 3) == 0 ? $urandom_range(1, len) : 0;
      send_pkt(len, eb, 1'($urandom_range(0, 1)));
    end
    drain();
    check_stats(e_ok, e_fifo, e_len, e_err);
    check("bp_total", st_ok + st_fifo + st_len + st_err, STATS ? base + 20 : 0);
    bp = 1'b0;
    @(posedge clk);
    #1;
    send_beat($urandom, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_beat($urandom, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    e_ok = 0;
    e_fifo = 0;
    e_len = 0;
    e_err = 0;
    @(negedge clk);
    check("midrst_m_tvalid", m.tvalid, 0);
    check_stats(0, 0, 0, 0);
    @(posedge clk);
    #1;
    send_pkt(2, 0, 1'b0);
    drain();
    check_stats(1, 0, 0, 0);
    @(posedge clk);
    #1;
    for (int p = 0; p < 5; p++)
      for (int b = 0; b < 2; b++) begin
        s2.tvalid = 1'b1;
        s2.tlast = b == 1;
        s2.tdata = 8'(p);
        @(posedge clk);
        #1;
      end
    s2.tvalid = 1'b0;
    s2.tlast = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sat_stat_ok", s2_ok, STATS ? 3 : 0);
    @(posedge clk);
    #1;
    s2.tvalid = 1'b1;
    s2.tlast = 1'b0;
    @(posedge clk);
    #1;
    s2.tlast = 1'b1;
    @(posedge clk);
    #1;
    s2.tvalid = 1'b0;
    s2.tlast = 1'b0;
    stat_clear2 = 1'b1;
    @(negedge clk);
    check("clr_last_beat_out", {m2.tvalid, m2.tlast, m2.tdrop}, 3'b110);
    @(posedge clk);
    #1;
    stat_clear2 = 1'b0;
    @(negedge clk);
    check("clr_stat_ok", s2_ok, 0);
    check("clr_stat_len", s2_len, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
